// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end.
//   XLEN          : datapath / address width
//   NOP_INSTR     : bubble encoding (addi x0,x0,0)
//   fetch_state_e : fetch FSM state encoding
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // FETCH: a request may be issued.
  // WAIT : a live request is outstanding.
  // DROP : a stale request is outstanding and its data must be discarded.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a one-entry skid buffer.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   flush_i                  : squash IF/ID to a bubble and empty the skid
//   stall_i                  : hold IF/ID; an arriving word is parked in the skid
//   in_valid_i/in_instr_i/in_pc_i : word delivered by the fetch FSM this cycle
//   full_o                   : skid holds a word
//   instr_o/pc_o/pc_plus4_o/valid_o : IF/ID register contents
module if_id_skid
  import riscv_pkg::*;
#(
  parameter int          XLEN = 32,
  parameter logic [31:0] NOP  = NOP_INSTR
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            in_valid_i,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            full_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o
);

  logic            skid_valid_q, skid_valid_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q,    skid_pc_d;
  logic [31:0]     instr_q,      instr_d;
  logic [XLEN-1:0] pc_q,         pc_d;
  logic [XLEN-1:0] pc_plus4_q,   pc_plus4_d;
  logic            valid_q,      valid_d;

  // The fetch FSM never issues while the skid is full, so a new word and a
  // full skid never coincide; the skid always drains before new data lands.
  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    pc_plus4_d   = pc_plus4_q;
    valid_d      = valid_q;
    if (flush_i) begin
      // Redirect wins over stall: everything fetched so far is wrong-path.
      skid_valid_d = 1'b0;
      valid_d      = 1'b0;
      instr_d      = NOP;
    end else if (stall_i) begin
      if (in_valid_i) begin
        skid_valid_d = 1'b1;
        skid_instr_d = in_instr_i;
        skid_pc_d    = in_pc_i;
      end
    end else if (skid_valid_q) begin
      skid_valid_d = 1'b0;
      instr_d      = skid_instr_q;
      pc_d         = skid_pc_q;
      pc_plus4_d   = skid_pc_q + XLEN'(4);
      valid_d      = 1'b1;
    end else if (in_valid_i) begin
      instr_d    = in_instr_i;
      pc_d       = in_pc_i;
      pc_plus4_d = in_pc_i + XLEN'(4);
      valid_d    = 1'b1;
    end else begin
      valid_d = 1'b0;
      instr_d = NOP;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP;
      skid_pc_q    <= '0;
      instr_q      <= NOP;
      pc_q         <= '0;
      pc_plus4_q   <= XLEN'(4);
      valid_q      <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      pc_plus4_q   <= pc_plus4_d;
      valid_q      <= valid_d;
    end
  end

  assign full_o      = skid_valid_q;
  assign instr_o     = instr_q;
  assign pc_o        = pc_q;
  assign pc_plus4_o  = pc_plus4_q;
  assign valid_o     = valid_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch front end: PC register, single-outstanding imem requests,
// execute-stage redirect handling and the IF/ID register (via if_id_skid).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   PCSrc, PCTargetE    : execute redirect request and target
//   StallD              : hold IF/ID
//   imem_req/imem_addr  : fetch request and address (the PC register)
//   imem_gnt            : memory accepts the request
//   imem_rvalid/rdata   : in-order read response
//   InstrD/PCD/PCPlus4D/ValidD : IF/ID register
//   FlushE              : squash ID/EX (mirrors PCSrc)
//   dbg_state_o         : current fetch FSM state
//
// imem handshake: an address transfers on a cycle where imem_req and imem_gnt
// are both high; imem_req is never held waiting on anything but the FSM/skid,
// and exactly one imem_rvalid pulse follows each transfer, at least one cycle
// later.
module fetch_redirect_unit
  import riscv_pkg::*;
#(
  parameter int               XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter logic [31:0]      NOP      = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallD,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FlushE,
  output fetch_state_e    dbg_state_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            skid_full;
  logic            accept;
  logic            deliver;
  logic [XLEN-1:0] target_aligned;

  assign target_aligned = {PCTargetE[XLEN-1:2], 2'b00};
  assign accept         = imem_req & imem_gnt;

  // State register, PC and in-flight address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // Next-state logic. A redirect turns any outstanding request into a stale
  // one; if the response arrives in the redirect cycle itself it is simply
  // not delivered and nothing stale remains.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    case (state_q)
      FETCH: begin
        if (accept) begin
          inflight_pc_d = pc_q;
          pc_d          = pc_q + XLEN'(4);
          state_d       = PCSrc ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) state_d = FETCH;
        else if (PCSrc)  state_d = DROP;
      end
      DROP: begin
        if (imem_rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (PCSrc) pc_d = target_aligned;
  end

  // Outputs. imem_req is gated by rst_n so nothing is requested during reset.
  always_comb begin
    imem_req = rst_n && (state_q == FETCH) && !skid_full;
    deliver  = (state_q == WAIT) && imem_rvalid && !PCSrc;
  end

  assign imem_addr   = pc_q;
  assign FlushE      = PCSrc;
  assign dbg_state_o = state_q;

  if_id_skid #(
    .XLEN (XLEN),
    .NOP  (NOP)
  ) u_if_id (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (PCSrc),
    .stall_i    (StallD),
    .in_valid_i (deliver),
    .in_instr_i (imem_rdata),
    .in_pc_i    (inflight_pc_q),
    .full_o     (skid_full),
    .instr_o    (InstrD),
    .pc_o       (PCD),
    .pc_plus4_o (PCPlus4D),
    .valid_o    (ValidD)
  );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
module tb_fetch_redirect_unit;
  import riscv_pkg::*;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic         clk;
  logic         rst_n;
  logic         PCSrc;
  logic [31:0]  PCTargetE;
  logic         StallD;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  logic [31:0]  InstrD;
  logic [31:0]  PCD;
  logic [31:0]  PCPlus4D;
  logic         ValidD;
  logic         FlushE;
  fetch_state_e dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_redirect_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCSrc       (PCSrc),
    .PCTargetE   (PCTargetE),
    .StallD      (StallD),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .ValidD      (ValidD),
    .FlushE      (FlushE),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full round trip: grant in the first cycle, rvalid in the next,
  // then check IF/ID one cycle after the response.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] word);
    logic [31:0] exp_p4;
    exp_p4 = addr + 32'd4;
    imem_gnt = 1'b1;
    #1;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== addr) begin
      n_fail++;
      $display("FAIL fetch_req: req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, addr);
    end
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_wait_req: req=%b expected 0", imem_req);
    end
    tick();
    imem_rvalid = 1'b0;
    #1;
    n_cmp++;
    if (ValidD !== 1'b1 || InstrD !== word || PCD !== addr || PCPlus4D !== exp_p4) begin
      n_fail++;
      $display("FAIL fetch_ifid: valid=%b instr=%h pc=%h pc4=%h expected 1 %h %h %h",
               ValidD, InstrD, PCD, PCPlus4D, word, addr, exp_p4);
    end
  endtask

  // Redirect from FETCH with no grant: PC takes the target next cycle.
  task automatic redirect(input logic [31:0] target);
    PCSrc     = 1'b1;
    PCTargetE = target;
    tick();
    PCSrc     = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (ValidD !== 1'b0 || InstrD !== NOP_W || PCD !== 32'h0 || PCPlus4D !== 32'h4) begin
      n_fail++;
      $display("FAIL reset_ifid: valid=%b instr=%h pc=%h pc4=%h expected 0 00000013 0 4",
               ValidD, InstrD, PCD, PCPlus4D);
    end
    n_cmp++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || FlushE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_imem: req=%b addr=%h flush=%b expected 0 0 0", imem_req, imem_addr, FlushE);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    fetch_one(32'h0, 32'h0010_0093);
    fetch_one(32'h4, 32'h0020_0113);
    fetch_one(32'h8, 32'h0030_8193);
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1'b1;
    #1;
    n_cmp++;
    if (imem_addr !== 32'hC) begin
      n_fail++;
      $display("FAIL rw_addr: addr=%h expected 0000000c", imem_addr);
    end
    tick();
    imem_gnt  = 1'b0;
    PCSrc     = 1'b1;
    PCTargetE = 32'h100;
    #1;
    n_cmp++;
    if (FlushE !== 1'b1 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_flush: flush=%b req=%b expected 1 0", FlushE, imem_req);
    end
    tick();
    PCSrc       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_0013;
    #1;
    n_cmp++;
    if (dbg_state !== DROP || imem_req !== 1'b0 || imem_addr !== 32'h100 ||
        ValidD !== 1'b0 || InstrD !== NOP_W) begin
      n_fail++;
      $display("FAIL rw_drop: state=%0d req=%b addr=%h valid=%b instr=%h expected 2 0 100 0 00000013",
               dbg_state, imem_req, imem_addr, ValidD, InstrD);
    end
    tick();
    imem_rvalid = 1'b0;
    #1;
    n_cmp++;
    if (dbg_state !== FETCH || ValidD !== 1'b0 || InstrD !== NOP_W) begin
      n_fail++;
      $display("FAIL rw_discard: state=%0d valid=%b instr=%h expected 0 0 00000013",
               dbg_state, ValidD, InstrD);
    end
    fetch_one(32'h100, 32'h0040_0213);
  endtask

  task automatic test_redirect_gnt();
    redirect(32'h20);
    imem_gnt  = 1'b1;
    PCSrc     = 1'b1;
    PCTargetE = 32'h40;
    #1;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      n_fail++;
      $display("FAIL rg_req: req=%b addr=%h expected 1 00000020", imem_req, imem_addr);
    end
    tick();
    imem_gnt    = 1'b0;
    PCSrc       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0013;
    #1;
    n_cmp++;
    if (dbg_state !== DROP || imem_req !== 1'b0 || imem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL rg_drop: state=%0d req=%b addr=%h expected 2 0 00000040", dbg_state, imem_req, imem_addr);
    end
    tick();
    imem_rvalid = 1'b0;
    #1;
    n_cmp++;
    if (ValidD !== 1'b0 || InstrD !== NOP_W) begin
      n_fail++;
      $display("FAIL rg_stale: valid=%b instr=%h expected 0 00000013", ValidD, InstrD);
    end
    fetch_one(32'h40, 32'h0050_0293);
  endtask

  task automatic test_stall();
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0060_0313;
    tick();
    imem_rvalid = 1'b0;
    StallD      = 1'b1;
    imem_gnt    = 1'b1;
    #1;
    n_cmp++;
    if (ValidD !== 1'b1 || InstrD !== 32'h0060_0313 || PCD !== 32'h44 ||
        imem_req !== 1'b1 || imem_addr !== 32'h48) begin
      n_fail++;
      $display("FAIL st_first: valid=%b instr=%h pc=%h req=%b addr=%h expected 1 00600313 44 1 48",
               ValidD, InstrD, PCD, imem_req, imem_addr);
    end
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0070_0393;
    #1;
    n_cmp++;
    if (InstrD !== 32'h0060_0313 || ValidD !== 1'b1) begin
      n_fail++;
      $display("FAIL st_hold1: instr=%h valid=%b expected 00600313 1", InstrD, ValidD);
    end
    tick();
    imem_rvalid = 1'b0;
    #1;
    n_cmp++;
    if (InstrD !== 32'h0060_0313 || imem_req !== 1'b0 || dbg_state !== FETCH) begin
      n_fail++;
      $display("FAIL st_hold2: instr=%h req=%b state=%0d expected 00600313 0 0", InstrD, imem_req, dbg_state);
    end
    tick();
    StallD = 1'b0;
    #1;
    n_cmp++;
    if (InstrD !== 32'h0060_0313 || ValidD !== 1'b1 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL st_hold3: instr=%h valid=%b req=%b expected 00600313 1 0", InstrD, ValidD, imem_req);
    end
    tick();
    #1;
    n_cmp++;
    if (InstrD !== 32'h0070_0393 || PCD !== 32'h48 || PCPlus4D !== 32'h4C || ValidD !== 1'b1 ||
        imem_req !== 1'b1 || imem_addr !== 32'h4C) begin
      n_fail++;
      $display("FAIL st_drain: instr=%h pc=%h pc4=%h valid=%b req=%b addr=%h expected 00700393 48 4c 1 1 4c",
               InstrD, PCD, PCPlus4D, ValidD, imem_req, imem_addr);
    end
    tick();
    #1;
    n_cmp++;
    if (ValidD !== 1'b0 || InstrD !== NOP_W) begin
      n_fail++;
      $display("FAIL st_nodup: valid=%b instr=%h expected 0 00000013", ValidD, InstrD);
    end
  endtask

  task automatic test_wrap();
    redirect(32'hFFFF_FFFF);
    #1;
    n_cmp++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_align: addr=%h expected fffffffc", imem_addr);
    end
    fetch_one(32'hFFFF_FFFC, 32'h0080_0413);
    n_cmp++;
    if (PCPlus4D !== 32'h0 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_pc: pc4=%h addr=%h expected 0 0", PCPlus4D, imem_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    fetch_one(32'h0, 32'h0090_0493);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    #1;
    n_cmp++;
    if (dbg_state !== WAIT) begin
      n_fail++;
      $display("FAIL rst_mid_state: state=%0d expected 1", dbg_state);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ValidD !== 1'b0 || InstrD !== NOP_W || PCD !== 32'h0 || PCPlus4D !== 32'h4 ||
        imem_req !== 1'b0 || imem_addr !== 32'h0 || dbg_state !== FETCH) begin
      n_fail++;
      $display("FAIL rst_mid_vals: valid=%b instr=%h pc=%h pc4=%h req=%b addr=%h state=%0d expected 0 13 0 4 0 0 0",
               ValidD, InstrD, PCD, PCPlus4D, imem_req, imem_addr, dbg_state);
    end
    tick();
    tick();
    rst_n = 1'b1;
    fetch_one(32'h0, 32'h00A0_0513);
  endtask

  initial begin
    rst_n       = 1'b1;
    PCSrc       = 1'b0;
    PCTargetE   = 32'h0;
    StallD      = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    #1;
    rst_n = 1'b0;

    test_reset();
    test_sequential();
    test_redirect_wait();
    test_redirect_gnt();
    test_stall();
    test_wrap();
    test_reset_mid_wait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
